// File: rtl/sized_data_memory_if.sv
// Request/response bundle for sized_data_memory.
// Signal suffixes are named from the memory's point of view.
interface sized_data_memory_if;
  logic        reqValid_i;
  logic        reqReady_o;
  logic        reqWrite_i;
  logic [1:0]  reqSize_i;
  logic        reqSigned_i;
  logic [31:0] address_i;
  logic [31:0] dataWrite_i;
  logic        respValid_o;
  logic        respError_o;
  logic [31:0] dataRead_o;

  modport master (
    output reqValid_i, reqWrite_i, reqSize_i, reqSigned_i, address_i, dataWrite_i,
    input  reqReady_o, respValid_o, respError_o, dataRead_o
  );

  modport slave (
    input  reqValid_i, reqWrite_i, reqSize_i, reqSigned_i, address_i, dataWrite_i,
    output reqReady_o, respValid_o, respError_o, dataRead_o
  );
endinterface

// File: rtl/sized_data_memory.sv
// Big-endian byte-addressed data memory with byte/half/word accesses.
// Four byte-wide banks indexed by word row; lane 0 holds the byte at
// offset 0, which is the most significant byte of an aligned word.
// Misaligned accesses either split over two rows or are rejected.
module sized_data_memory #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  sized_data_memory_if.slave  bus
);
  localparam int ROW_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam int ROWS  = 1 << ROW_W;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t      state_q;
  logic        write_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, partial_q;
  logic        resp_valid_q, resp_error_q;
  logic [31:0] data_read_q;

  // In SPLIT the latched request drives the datapath, otherwise the bus does.
  logic        in_split, accept;
  logic        cur_write, cur_signed;
  logic [1:0]  cur_size, offset;
  logic [31:0] cur_addr, cur_wdata;
  logic [2:0]  cur_nb;
  logic [32:0] end_addr;
  logic        size_err, range_err, misaligned, req_err;
  logic [ROW_W-1:0] row_idx;

  assign in_split   = (state_q == SPLIT);
  assign cur_write  = in_split ? write_q  : bus.reqWrite_i;
  assign cur_signed = in_split ? signed_q : bus.reqSigned_i;
  assign cur_size   = in_split ? size_q   : bus.reqSize_i;
  assign cur_addr   = in_split ? addr_q   : bus.address_i;
  assign cur_wdata  = in_split ? wdata_q  : bus.dataWrite_i;
  assign offset     = cur_addr[1:0];

  assign bus.reqReady_o = rst_ni & (state_q == IDLE);
  assign accept         = bus.reqValid_i & bus.reqReady_o;

  // Number of bytes touched by the access.
  always_comb begin
    cur_nb = 3'd4;
    case (cur_size)
      2'b00:   cur_nb = 3'd1;
      2'b01:   cur_nb = 3'd2;
      default: cur_nb = 3'd4;
    endcase
  end

  // Last byte must lie inside the array; a carry past bit 31 also counts.
  assign end_addr   = {1'b0, cur_addr} + {30'd0, cur_nb} - 33'd1;
  assign size_err   = (cur_size == 2'b11);
  assign range_err  = |(end_addr >> ADDR_WIDTH);
  assign misaligned = ({1'b0, offset} + cur_nb) > 3'd4;
  assign req_err    = size_err | range_err | (misaligned & ~MISALIGN_SPLIT);
  assign row_idx    = ROW_W'((cur_addr >> 2) + {31'd0, in_split});

  logic [2:0]  lane_k   [4];
  logic [2:0]  lane_sig [4];
  logic [7:0]  lane_wb  [4];
  logic [31:0] lane_rd  [4];
  logic [3:0]  lane_act, lane_we;

  // lane_k is the byte index within the access (0 = MSB) served by this
  // lane; lane_sig is that byte's significance in the right-justified data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank_q [ROWS];

    assign lane_k[gi]   = in_split ? (3'(gi) + 3'd4 - {1'b0, offset})
                                   : (3'(gi) - {1'b0, offset});
    assign lane_act[gi] = (in_split | (2'(gi) >= offset)) & (lane_k[gi] < cur_nb);
    assign lane_sig[gi] = cur_nb - 3'd1 - lane_k[gi];
    assign lane_wb[gi]  = 8'(cur_wdata >> {lane_sig[gi], 3'b000});
    assign lane_we[gi]  = lane_act[gi] & cur_write & (in_split | (accept & ~req_err));

    // Byte-lane storage; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
      if (lane_we[gi]) bank_q[row_idx] <= lane_wb[gi];
    end

    assign lane_rd[gi] = lane_act[gi] ? ({24'd0, bank_q[row_idx]} << {lane_sig[gi], 3'b000})
                                      : 32'd0;
  end

  // Merge lane bytes; the second row adds to the bytes captured from the first.
  logic [31:0] raw_d;
  always_comb begin
    raw_d = in_split ? partial_q : 32'd0;
    for (int i = 0; i < 4; i++) raw_d = raw_d | lane_rd[i];
  end

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'b00:   return {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Control FSM: accept, split into two rows when needed, register response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      data_read_q  <= 32'd0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      partial_q    <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              data_read_q  <= 32'd0;
            end else if (misaligned) begin
              state_q   <= SPLIT;
              write_q   <= cur_write;
              signed_q  <= cur_signed;
              size_q    <= cur_size;
              addr_q    <= cur_addr;
              wdata_q   <= cur_wdata;
              partial_q <= raw_d;
            end else begin
              resp_valid_q <= 1'b1;
              if (!cur_write) data_read_q <= extend(raw_d, cur_size, cur_signed);
            end
          end
        end
        SPLIT: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
          if (!write_q) data_read_q <= extend(raw_d, size_q, signed_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.respValid_o = resp_valid_q;
  assign bus.respError_o = resp_error_q;
  assign bus.dataRead_o  = data_read_q;
endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: one instance with misaligned splitting, one
// without. A byte-array model predicts every response; a negedge process
// checks valid/ready/error/data each cycle, and directed loads pin literals.
module tb_sized_data_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sized_data_memory_if bus_s ();
  sized_data_memory_if bus_n ();

  sized_data_memory #(.ADDR_WIDTH(10), .MISALIGN_SPLIT(1'b1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_s));
  sized_data_memory #(.ADDR_WIDTH(10), .MISALIGN_SPLIT(1'b0)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_n));

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] data;
  } resp_t;

  resp_t       expq [2][$];
  logic [7:0]  mm [2][1024];
  logic [31:0] model_last [2];
  logic [31:0] cur_exp [2];
  int          busy_pc [2];
  int          pcnt = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string nm, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", nm, d, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdata(input int d);
    return (d == 0) ? bus_s.dataRead_o : bus_n.dataRead_o;
  endfunction
  function automatic logic [31:0] rvalid(input int d);
    return (d == 0) ? 32'(bus_s.respValid_o) : 32'(bus_n.respValid_o);
  endfunction
  function automatic logic [31:0] rerror(input int d);
    return (d == 0) ? 32'(bus_s.respError_o) : 32'(bus_n.respError_o);
  endfunction
  function automatic logic [31:0] rready(input int d);
    return (d == 0) ? 32'(bus_s.reqReady_o) : 32'(bus_n.reqReady_o);
  endfunction

  // Per-cycle compare of both instances against the queued expectations.
  always @(negedge clk) begin
    logic [31:0] dr;
    resp_t       f;
    bit          due_now;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) cur_exp[d] = 32'd0;
      due_now = (expq[d].size() > 0) && (expq[d][0].due == pcnt);
      chk("resp_valid", d, rvalid(d), 32'(due_now));
      chk("req_ready", d, rready(d), 32'(rst_n && (pcnt != busy_pc[d])));
      if (due_now) begin
        f = expq[d].pop_front();
        chk("resp_error", d, rerror(d), 32'(f.err));
        cur_exp[d] = f.data;
      end
      dr = rdata(d);
      chk("data_read", d, dr, cur_exp[d]);
    end
  end

  task automatic drive(input int d, input bit v, input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a, input logic [31:0] wd);
    bus_s.reqValid_i = 1'b0;
    bus_n.reqValid_i = 1'b0;
    if (d == 0) begin
      bus_s.reqValid_i = v;   bus_s.reqWrite_i = wr; bus_s.reqSize_i = sz;
      bus_s.reqSigned_i = sg; bus_s.address_i = a;   bus_s.dataWrite_i = wd;
    end else begin
      bus_n.reqValid_i = v;   bus_n.reqWrite_i = wr; bus_n.reqSize_i = sz;
      bus_n.reqSigned_i = sg; bus_n.address_i = a;   bus_n.dataWrite_i = wd;
    end
  endtask

  // Predict the response from byte-level rules, then present the request.
  // A split request is followed by a junk request that must be ignored.
  task automatic issue(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int nb, off;
    bit err, spl;
    logic [31:0] res, raw, tmp, fill;
    resp_t r;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    err = (sz == 2'd3) || (({32'd0, a} + 64'(nb) - 64'd1) >= 64'd1024) ||
          (d == 1 && off + nb > 4);
    spl = !err && (off + nb > 4);
    if (err) res = 32'd0;
    else if (wr) begin
      for (int k = 0; k < nb; k++) begin
        tmp = wd >> (8 * (nb - 1 - k));
        mm[d][int'(a) + k] = tmp[7:0];
      end
      res = model_last[d];
    end else begin
      raw = 32'd0;
      for (int k = 0; k < nb; k++) raw = (raw << 8) | {24'd0, mm[d][int'(a) + k]};
      fill = 32'hFFFF_FFFF;
      if (sg && nb < 4 && raw[8 * nb - 1]) raw = raw | (fill << (8 * nb));
      res = raw;
    end
    model_last[d] = res;
    @(posedge clk); #1;
    drive(d, 1'b1, wr, sz, sg, a, wd);
    r.due = pcnt + (spl ? 2 : 1); r.err = err; r.data = res;
    expq[d].push_back(r);
    if (spl) begin
      busy_pc[d] = pcnt + 1;
      @(posedge clk); #1;
      drive(d, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF);
    end
  endtask

  // Let the last issued request complete; returns on the negedge of its response.
  task automatic settle();
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic lit_load(input int d, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] exp, input bit exp_err);
    issue(d, 1'b0, sz, sg, a, 32'd0);
    settle();
    chk("lit_valid", d, rvalid(d), 32'd1);
    chk("lit_error", d, rerror(d), 32'(exp_err));
    chk("lit_data", d, rdata(d), exp);
  endtask

  logic [31:0] be_bytes [4];
  logic [31:0] pat;
  logic [31:0] ra;
  int          sel;

  initial begin
    be_bytes = '{32'hDE, 32'hAD, 32'hBE, 32'hEF};
    busy_pc = '{-10, -10};
    model_last = '{32'd0, 32'd0};
    cur_exp = '{32'd0, 32'd0};
    bus_s.reqWrite_i = 0; bus_s.reqSize_i = 0; bus_s.reqSigned_i = 0;
    bus_s.address_i = 0;  bus_s.dataWrite_i = 0;
    bus_n.reqWrite_i = 0; bus_n.reqSize_i = 0; bus_n.reqSigned_i = 0;
    bus_n.address_i = 0;  bus_n.dataWrite_i = 0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, rready(d), 32'd0);
      chk("rst_valid", d, rvalid(d), 32'd0);
      chk("rst_data", d, rdata(d), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 0, rready(0), 32'd1);

    // Fill both memories: row r holds {r, ~r, r, ~r}
    for (int r = 0; r < 256; r++) begin
      pat = {8'(r), ~8'(r), 8'(r), ~8'(r)};
      issue(0, 1'b1, 2'd2, 1'b0, 32'(r * 4), pat);
      issue(1, 1'b1, 2'd2, 1'b0, 32'(r * 4), pat);
    end
    settle();

    // Big-endian word store, byte and half loads
    issue(0, 1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) lit_load(0, 2'd0, 1'b0, 32'h010 + 32'(i), be_bytes[i], 1'b0);
    lit_load(0, 2'd1, 1'b1, 32'h012, 32'hFFFF_BEEF, 1'b0);
    lit_load(0, 2'd1, 1'b0, 32'h012, 32'h0000_BEEF, 1'b0);

    // Split word store at 0x021
    issue(0, 1'b1, 2'd2, 1'b0, 32'h021, 32'h1122_3344);
    @(negedge clk);
    chk("split_ready_low", 0, rready(0), 32'd0);
    settle();
    chk("split_resp", 0, rvalid(0), 32'd1);
    lit_load(0, 2'd2, 1'b0, 32'h020, 32'h0811_2233, 1'b0);
    lit_load(0, 2'd2, 1'b0, 32'h024, 32'h44F6_09F6, 1'b0);

    // No-split instance: misaligned accesses are errors
    lit_load(1, 2'd2, 1'b0, 32'h020, 32'h08F7_08F7, 1'b0);
    lit_load(1, 2'd2, 1'b0, 32'h021, 32'h0, 1'b1);
    issue(1, 1'b1, 2'd1, 1'b0, 32'h023, 32'h0000_ABCD);
    settle();
    chk("half_store_err", 1, rerror(1), 32'd1);
    lit_load(1, 2'd2, 1'b0, 32'h020, 32'h08F7_08F7, 1'b0);

    // Range and size errors, nothing written
    lit_load(0, 2'd0, 1'b0, 32'h400, 32'h0, 1'b1);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h3FE, 32'h1234_5678);
    settle();
    chk("wrap_store_err", 0, rerror(0), 32'd1);
    issue(0, 1'b1, 2'd3, 1'b0, 32'h3FC, 32'h1234_5678);
    settle();
    chk("size3_err", 0, rerror(0), 32'd1);
    lit_load(0, 2'd2, 1'b0, 32'h3FC, 32'hFF00_FF00, 1'b0);

    // Reset in the middle of a split store at 0x005
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h005, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    mm[0][5] = 8'hCA; mm[0][6] = 8'hFE; mm[0][7] = 8'hF0;
    model_last = '{32'd0, 32'd0};
    busy_pc = '{-10, -10};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", 0, rready(0), 32'd1);
    lit_load(0, 2'd0, 1'b0, 32'h005, 32'hCA, 1'b0);
    lit_load(0, 2'd0, 1'b0, 32'h006, 32'hFE, 1'b0);
    lit_load(0, 2'd0, 1'b0, 32'h007, 32'hF0, 1'b0);
    lit_load(0, 2'd0, 1'b0, 32'h008, 32'h02, 1'b0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       ra = 32'h400 + $urandom_range(0, 15);
        1:       ra = 32'd1020 + $urandom_range(0, 3);
        2:       ra = (32'd1 << $urandom_range(10, 31)) | $urandom_range(0, 7);
        3:       ra = 32'h020 + $urandom_range(0, 15);
        default: ra = $urandom_range(0, 1023);
      endcase
      issue(int'($urandom_range(0, 1)), 1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            1'($urandom), ra, $urandom);
      if ($urandom_range(0, 7) == 0) settle();
    end
    settle();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("drain", d, 32'(expq[d].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sized_data_memory.md
# sized_data_memory

Byte-addressed, big-endian data memory with a valid/ready request port, byte/half/word access sizes, sign or zero extension on loads, and optional splitting of misaligned accesses into two internal cycles. It is the clocked, parametrised successor to the combinational data memory and sits on the datapath's load/store stage. Storage is four byte-wide banks indexed by word row. Out-of-range, illegal-size and (optionally) misaligned requests complete with an error response.

## Interface
- ADDR_WIDTH, 10, byte address bits; capacity = 2^ADDR_WIDTH bytes, must be ≥ 2.
- MISALIGN_SPLIT, 1, 1 = misaligned accesses execute as two row accesses; 0 = misaligned accesses return an error.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- reqValid_i  input  1  request present.
- reqReady_o  output  1  block can accept a request this cycle.
- reqWrite_i  input  1  1 = store, 0 = load.
- reqSize_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- reqSigned_i  input  1  load only: 1 = sign-extend, 0 = zero-extend.
- address_i  input  32  byte address of the most significant byte of the access.
- dataWrite_i  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- respValid_o  output  1  one-cycle completion pulse.
- respError_o  output  1  qualifies respValid_o; 1 = request rejected.
- dataRead_o  output  32  load result, right-justified and extended.

## Operation
- Handshake: the request is accepted on a rising edge where reqValid_i & reqReady_o. reqReady_o = 1 in IDLE, 0 in SPLIT, and 0 while rst_ni is low.
- Byte order is big-endian. The byte at address_i is the most significant byte of the accessed unit. Half store: dataWrite_i[15:8] goes to addr and [7:0] to addr+1. Word store: [31:24] goes to addr, through [7:0] at addr+3.
- Row = address_i[ADDR_WIDTH-1:2] and offset = address_i[1:0]. An access is misaligned when offset + size_bytes > 4, i.e. half at offset 3, or word at offset ≠ 0.
- Error checks are evaluated at acceptance, in priority order:
  - size 11
  - address_i[31:ADDR_WIDTH] ≠ 0, or addr + size_bytes − 1 ≥ 2^ADDR_WIDTH (no wrap-around)
  - misaligned with MISALIGN_SPLIT = 0
- On error: no bytes are written, respError_o = 1, and dataRead_o = 0.
- States:
  - IDLE: accept a request. An aligned or error request completes from IDLE. A legal misaligned request (MISALIGN_SPLIT = 1) accesses the bytes in the first row, latches the request and partial read data, and moves to SPLIT.
  - SPLIT: access the remaining bytes in row+1, complete the response, return to IDLE. New requests are not accepted in SPLIT.
- Loads: the assembled bytes are right-justified. Bits above the size are filled with the top data bit if reqSigned_i, else 0. dataRead_o updates only on load or error responses and holds its value otherwise (stores leave it unchanged).
- Stores write only the addressed byte lanes; other lanes keep their contents.
- Memory contents are not reset; their initial value is undefined.

## Timing
- Reset values: state IDLE, respValid_o 0, respError_o 0, dataRead_o 0, reqReady_o 0 while in reset and 1 after.
- Aligned or error request accepted at edge N: respValid_o = 1 during cycle N→N+1 (latency 1). Throughput is one request per cycle back-to-back.
- Split request accepted at edge N:
  - first-row bytes are committed at edge N
  - reqReady_o = 0 for cycle N→N+1
  - second-row bytes are committed at edge N+1
  - respValid_o = 1 during cycle N+1→N+2
  - reqReady_o returns to 1 in cycle N+1→N+2
- Each respValid_o pulse lasts exactly one cycle. There is no response backpressure.
- Load data reflects all stores accepted on earlier edges, including the immediately preceding cycle.
- Reset mid-SPLIT: first-row bytes already written remain written. The second part is dropped, no response is issued, and the block returns to IDLE.

## Test plan
- Word store of 0xDEADBEEF at 0x010, then byte loads at 0x010..0x013 → 0xDE, 0xAD, 0xBE, 0xEF, each zero-extended, each respValid_o 1 cycle after acceptance.
- Half load of 0x012 (stored 0xBEEF): reqSigned_i = 1 → 0xFFFFBEEF; reqSigned_i = 0 → 0x0000BEEF.
- MISALIGN_SPLIT = 1: word store of 0x11223344 at 0x021 → reqReady_o low for 1 cycle and response at 2 cycles. A word load at 0x020 then returns 0xXX112233, with the pre-existing byte at 0x020 unchanged.
- MISALIGN_SPLIT = 0: word load at 0x021 → respError_o = 1, dataRead_o = 0. Half store at 0x023 → error, and a word load at 0x020 shows the row unchanged.
- Address 0x400 (ADDR_WIDTH = 10), word at 0x3FE, or reqSize_i = 11 → error response with no write; back-to-back aligned requests produce one response per cycle.
- Assert rst_ni low during SPLIT of a word store at 0x005 → no respValid_o. Bytes at 0x005..0x007 are updated and 0x008 is not. reqReady_o = 1 on the first cycle after reset is released.
